// File: rtl/bs_batch_pricer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | bs_batch_pricer: round-robin request front end for the Black-Scholes core,  |
// | holds operands for CORE_LAT cycles and queues results in a FIFO.            |
// | Optional: define BSP_CLAMP_EN to clamp negative core prices to zero.        |
// | Revision: 1.0                                                               |
// +----------------------------------------------------------------------------+
module bs_batch_pricer #(
  parameter int WIDTH    = 32,
  parameter int FRAC     = 16,
  parameter int NCH      = 4,
  parameter int CORE_LAT = 64,
  parameter int DEPTH    = 8,
  parameter int TAGW     = 4,
  localparam int CHW     = (NCH > 1) ? $clog2(NCH) : 1
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [NCH-1:0]       in_valid,
  output logic [NCH-1:0]       in_ready,
  input  logic [NCH*WIDTH-1:0] in_spot,
  input  logic [NCH*WIDTH-1:0] in_strike,
  input  logic [NCH*WIDTH-1:0] in_timetm,
  input  logic [NCH*WIDTH-1:0] in_sigma,
  input  logic [NCH*WIDTH-1:0] in_rate,
  input  logic [NCH-1:0]       in_otype,
  input  logic [NCH*TAGW-1:0]  in_tag,
  output logic [WIDTH-1:0]     core_spot,
  output logic [WIDTH-1:0]     core_strike,
  output logic [WIDTH-1:0]     core_timetm,
  output logic [WIDTH-1:0]     core_sigma,
  output logic [WIDTH-1:0]     core_rate,
  output logic                 core_otype,
  output logic                 core_start,
  input  logic [WIDTH-1:0]     core_price,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [WIDTH-1:0]     out_price,
  output logic [CHW-1:0]       out_ch,
  output logic [TAGW-1:0]      out_tag,
  output logic                 out_err
);
  localparam int CHW1 = CHW + 1;
  localparam int CNTW = (CORE_LAT > 1) ? $clog2(CORE_LAT) : 1;
  localparam int AW   = $clog2(DEPTH);
  localparam int AW1  = AW + 1;

  if (FRAC < 0 || FRAC >= WIDTH || NCH < 1 || CORE_LAT < 1 || DEPTH < 2 ||
      (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_params
    $error("bs_batch_pricer: illegal parameter set");
  end

  typedef enum logic [1:0] {S_IDLE = 2'd0, S_RUN = 2'd1, S_ERR = 2'd2} state_t;

  state_t            state_q;
  logic [CHW-1:0]    rr_ptr_q, ch_q;
  logic [TAGW-1:0]   tag_q;
  logic [CNTW-1:0]   cnt_q;
  logic [WIDTH-1:0]  spot_q, strike_q, timetm_q, sigma_q, rate_q;
  logic              otype_q, start_q;

  logic [AW-1:0]     wr_q, rd_q;
  logic [AW:0]       count_q;
  logic [WIDTH-1:0]  price_mem [DEPTH];
  logic [CHW-1:0]    ch_mem    [DEPTH];
  logic [TAGW-1:0]   tag_mem   [DEPTH];
  logic              err_mem   [DEPTH];

  logic              grant_found;
  logic [CHW-1:0]    grant_ch;
  logic [CHW:0]      scan;
  logic [NCH-1:0]    ready_d;

  // Scan channels starting at rr_ptr, wrapping at NCH (need not be a power of 2).
  always_comb begin
    grant_found = 1'b0;
    grant_ch    = '0;
    scan        = '0;
    for (int k = 0; k < NCH; k++) begin
      scan = {1'b0, rr_ptr_q} + CHW1'(k);
      if (scan >= CHW1'(NCH)) scan = scan - CHW1'(NCH);
      if (!grant_found && in_valid[scan[CHW-1:0]]) begin
        grant_found = 1'b1;
        grant_ch    = scan[CHW-1:0];
      end
    end
  end

  always_comb begin
    ready_d = '0;
    if (!reset && state_q == S_IDLE && count_q < AW1'(DEPTH) && grant_found)
      ready_d[grant_ch] = 1'b1;
  end
  assign in_ready = ready_d;

  logic              accept;
  logic [WIDTH-1:0]  sel_spot, sel_strike, sel_timetm, sel_sigma, sel_rate;
  logic [TAGW-1:0]   sel_tag;
  logic              sel_bad;

  assign accept     = |(in_valid & ready_d);
  assign sel_spot   = in_spot  [int'(grant_ch)*WIDTH +: WIDTH];
  assign sel_strike = in_strike[int'(grant_ch)*WIDTH +: WIDTH];
  assign sel_timetm = in_timetm[int'(grant_ch)*WIDTH +: WIDTH];
  assign sel_sigma  = in_sigma [int'(grant_ch)*WIDTH +: WIDTH];
  assign sel_rate   = in_rate  [int'(grant_ch)*WIDTH +: WIDTH];
  assign sel_tag    = in_tag   [int'(grant_ch)*TAGW +: TAGW];

  function automatic logic nonpos(input logic [WIDTH-1:0] v);
    return v[WIDTH-1] | (v == '0);
  endfunction

  assign sel_bad = nonpos(sel_spot) | nonpos(sel_strike) | nonpos(sel_timetm) | nonpos(sel_sigma);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= S_IDLE;
      rr_ptr_q <= '0;
      ch_q     <= '0;
      tag_q    <= '0;
      cnt_q    <= '0;
      spot_q   <= '0;
      strike_q <= '0;
      timetm_q <= '0;
      sigma_q  <= '0;
      rate_q   <= '0;
      otype_q  <= 1'b0;
      start_q  <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (accept) begin
            spot_q   <= sel_spot;
            strike_q <= sel_strike;
            timetm_q <= sel_timetm;
            sigma_q  <= sel_sigma;
            rate_q   <= sel_rate;
            otype_q  <= in_otype[grant_ch];
            tag_q    <= sel_tag;
            ch_q     <= grant_ch;
            rr_ptr_q <= (grant_ch == CHW'(NCH - 1)) ? '0 : grant_ch + 1'b1;
            if (sel_bad) begin
              state_q <= S_ERR;
            end else begin
              state_q <= S_RUN;
              cnt_q   <= CNTW'(CORE_LAT - 1);
              start_q <= 1'b1;
            end
          end
        end
        S_RUN: begin
          if (cnt_q == '0) begin
            state_q <= S_IDLE;
            start_q <= 1'b0;
          end else begin
            cnt_q <= cnt_q - 1'b1;
          end
        end
        S_ERR:   state_q <= S_IDLE;
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign core_spot   = spot_q;
  assign core_strike = strike_q;
  assign core_timetm = timetm_q;
  assign core_sigma  = sigma_q;
  assign core_rate   = rate_q;
  assign core_otype  = otype_q;
  assign core_start  = start_q;

  logic             push, pop, push_err;
  logic [WIDTH-1:0] run_price, push_price;

`ifdef BSP_CLAMP_EN
  assign run_price = core_price[WIDTH-1] ? '0 : core_price;
`else
  assign run_price = core_price;
`endif

  assign push       = (state_q == S_RUN && cnt_q == '0) || state_q == S_ERR;
  assign push_err   = (state_q == S_ERR);
  assign push_price = push_err ? '0 : run_price;
  assign out_valid  = (count_q != '0);
  assign pop        = out_valid & out_ready;

  // Storage is not reset; outputs are masked by out_valid instead.
  always_ff @(posedge clk) begin
    if (push) begin
      price_mem[wr_q] <= push_price;
      ch_mem[wr_q]    <= ch_q;
      tag_mem[wr_q]   <= tag_q;
      err_mem[wr_q]   <= push_err;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_q    <= '0;
      rd_q    <= '0;
      count_q <= '0;
    end else begin
      if (push) wr_q <= wr_q + 1'b1;
      if (pop)  rd_q <= rd_q + 1'b1;
      case ({push, pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

  assign out_price = out_valid ? price_mem[rd_q] : '0;
  assign out_ch    = out_valid ? ch_mem[rd_q]    : '0;
  assign out_tag   = out_valid ? tag_mem[rd_q]   : '0;
  assign out_err   = out_valid ? err_mem[rd_q]   : 1'b0;

endmodule
`default_nettype wire

// File: tb/tb_bs_batch_pricer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_bs_batch_pricer: directed self-checking bench for bs_batch_pricer        |
// | (NCH=4, CORE_LAT=8, DEPTH=2).                                               |
// | Revision: 1.0                                                               |
// +----------------------------------------------------------------------------+
module tb_bs_batch_pricer;
  localparam int W  = 32;
  localparam int N  = 4;
  localparam int TG = 4;
  localparam int CL = 8;

  localparam logic [W-1:0] c_hundred = 32'h0064_0000;
  localparam logic [W-1:0] c_one     = 32'h0001_0000;
  localparam logic [W-1:0] c_sig     = 32'h0000_3333;
  localparam logic [W-1:0] c_rate    = 32'h0000_0CCD;
  localparam logic [W-1:0] c_price   = 32'h0045_0290;
  localparam logic [W-1:0] c_neg     = 32'hFFFF_0000;

  logic            clk = 1'b0;
  logic            reset;
  logic [N-1:0]    in_valid;
  wire  [N-1:0]    in_ready;
  logic [N*W-1:0]  in_spot, in_strike, in_timetm, in_sigma, in_rate;
  logic [N-1:0]    in_otype;
  logic [N*TG-1:0] in_tag;
  wire  [W-1:0]    core_spot, core_strike, core_timetm, core_sigma, core_rate;
  wire             core_otype, core_start;
  logic [W-1:0]    core_price;
  wire             out_valid;
  logic            out_ready;
  wire  [W-1:0]    out_price;
  wire  [1:0]      out_ch;
  wire  [TG-1:0]   out_tag;
  wire             out_err;

  int n_cmp = 0;
  int n_bad = 0;

  bs_batch_pricer #(.WIDTH(W), .FRAC(16), .NCH(N), .CORE_LAT(CL), .DEPTH(2), .TAGW(TG)) dut (
    .clk(clk), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_spot(in_spot), .in_strike(in_strike), .in_timetm(in_timetm),
    .in_sigma(in_sigma), .in_rate(in_rate), .in_otype(in_otype), .in_tag(in_tag),
    .core_spot(core_spot), .core_strike(core_strike), .core_timetm(core_timetm),
    .core_sigma(core_sigma), .core_rate(core_rate), .core_otype(core_otype),
    .core_start(core_start), .core_price(core_price),
    .out_valid(out_valid), .out_ready(out_ready), .out_price(out_price),
    .out_ch(out_ch), .out_tag(out_tag), .out_err(out_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic set_ch(input int ch, input logic [W-1:0] s, input logic [W-1:0] sig,
                        input logic [TG-1:0] tg);
    in_spot  [ch*W +: W]   = s;
    in_strike[ch*W +: W]   = c_hundred;
    in_timetm[ch*W +: W]   = c_one;
    in_sigma [ch*W +: W]   = sig;
    in_rate  [ch*W +: W]   = c_rate;
    in_otype [ch]          = 1'b0;
    in_tag   [ch*TG +: TG] = tg;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
    tick();
  endtask

  int edges, starts, ng, no, na;
  int g_ch [5];
  int g_t  [5];
  int o_ch [4];
  int o_tag[4];
  logic [N-1:0] w;
  logic saw_valid;

  initial begin
    reset = 1'b1; in_valid = '0; out_ready = 1'b0; core_price = c_price;
    in_spot = '0; in_strike = '0; in_timetm = '0; in_sigma = '0; in_rate = '0;
    in_otype = '0; in_tag = '0;
    tick();
    tick();
    check("rst_in_ready", in_ready, 0);
    check("rst_out_valid", out_valid, 0);
    check("rst_out_fields", {out_price, out_ch, out_tag, out_err}, 0);
    check("rst_core", {core_spot, core_sigma, core_otype, core_start}, 0);
    reset = 1'b0;
    tick();

    // Single valid job on ch0
    set_ch(0, c_hundred, c_sig, 4'd3);
    in_valid = 4'b0001;
    #1 check("t1_ready", in_ready, 4'b0001);
    tick();
    in_valid = '0;
    check("t1_core_spot", core_spot, c_hundred);
    edges = 0;
    starts = core_start ? 1 : 0;
    for (int i = 0; i < 20 && !out_valid; i++) begin
      tick();
      edges++;
      if (core_start) starts++;
    end
    check("t1_latency", edges, CL);
    check("t1_start_cycles", starts, CL);
    check("t1_result", {out_valid, out_price, out_ch, out_tag, out_err},
          {1'b1, c_price, 2'd0, 4'd3, 1'b0});
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check("t1_popped", out_valid, 0);

    // Four channels valid continuously
    do_reset();
    for (int c = 0; c < N; c++) set_ch(c, c_hundred, c_sig, TG'(c + 8));
    in_valid = 4'b1111; out_ready = 1'b1;
    ng = 0; no = 0;
    for (int c = 0; c < 40; c++) begin
      #1;
      w = in_valid & in_ready;
      if (w != '0 && ng < 5) begin
        g_ch[ng] = (w == 4'b0001) ? 0 : (w == 4'b0010) ? 1 : (w == 4'b0100) ? 2 : (w == 4'b1000) ? 3 : 9;
        g_t[ng]  = c;
        ng++;
      end
      if (out_valid && no < 4) begin
        o_ch[no]  = int'(out_ch);
        o_tag[no] = int'(out_tag);
        no++;
      end
      tick();
    end
    in_valid = '0;
    for (int i = 0; i < 20; i++) tick();
    check("t2_grant_count", ng, 5);
    for (int k = 0; k < 5; k++) check($sformatf("t2_grant%0d", k), g_ch[k], k % 4);
    for (int k = 0; k < 4; k++) check($sformatf("t2_space%0d", k), g_t[k+1] - g_t[k], CL + 1);
    check("t2_out_count", no, 4);
    for (int k = 0; k < 4; k++) check($sformatf("t2_out%0d", k), {o_ch[k], o_tag[k]}, {k, k + 8});
    out_ready = 1'b0;

    // Rejected operand: sigma = 0 on ch2
    set_ch(2, c_hundred, '0, 4'd5);
    in_valid = 4'b0100;
    #1 check("t3_ready", in_ready, 4'b0100);
    tick();
    in_valid = '0;
    check("t3_err_state", {out_valid, core_start}, 2'b00);
    tick();
    check("t3_result", {out_valid, out_price, out_ch, out_tag, out_err, core_start},
          {1'b1, 32'h0, 2'd2, 4'd5, 1'b1, 1'b0});
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;

    // FIFO full back-pressure, rr_ptr now 3
    set_ch(0, c_hundred, c_sig, 4'd1);
    set_ch(1, c_hundred, c_sig, 4'd2);
    set_ch(3, c_hundred, c_sig, 4'd4);
    in_valid = 4'b1011;
    na = 0;
    for (int c = 0; c < 30; c++) begin
      #1;
      w = in_valid & in_ready;
      if (w != '0 && na < 5) begin
        g_ch[na] = (w == 4'b0001) ? 0 : (w == 4'b0010) ? 1 : (w == 4'b0100) ? 2 : (w == 4'b1000) ? 3 : 9;
        na++;
      end
      tick();
      in_valid = in_valid & ~w;
    end
    check("t4_accepted", na, 2);
    check("t4_order", {g_ch[0], g_ch[1]}, {32'd3, 32'd0});
    check("t4_full_ready", in_ready, 0);
    check("t4_head0", {out_valid, out_ch, out_tag}, {1'b1, 2'd3, 4'd4});
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    #1 check("t4_third_ready", in_ready, 4'b0010);
    tick();
    in_valid = '0;
    for (int i = 0; i < 10; i++) tick();
    check("t4_head1", {out_valid, out_ch, out_tag}, {1'b1, 2'd0, 4'd1});
    out_ready = 1'b1;
    tick();
    check("t4_head2", {out_valid, out_ch, out_tag}, {1'b1, 2'd1, 4'd2});
    tick();
    out_ready = 1'b0;
    check("t4_empty", out_valid, 0);

    // Reset during RUN cycle 4
    set_ch(2, c_hundred, c_sig, 4'd7);
    in_valid = 4'b0100;
    tick();
    in_valid = '0;
    check("t5_running", core_start, 1);
    tick();
    tick();
    tick();
    reset = 1'b1;
    #1 check("t5_reset_outs", {core_start, core_spot, out_valid, in_ready}, 0);
    tick();
    reset = 1'b0;
    tick();
    in_valid = 4'b1111;
    #1 check("t5_ch0_first", in_ready, 4'b0001);
    in_valid = '0;
    saw_valid = 1'b0;
    for (int i = 0; i < 15; i++) begin
      tick();
      if (out_valid) saw_valid = 1'b1;
    end
    check("t5_no_result", saw_valid, 0);

    // Negative core price
    core_price = c_neg;
    set_ch(0, c_hundred, c_sig, 4'd6);
    in_valid = 4'b0001;
    tick();
    in_valid = '0;
    for (int i = 0; i < 20 && !out_valid; i++) tick();
`ifdef BSP_CLAMP_EN
    check("t6_price", {out_valid, out_price, out_err}, {1'b1, 32'h0, 1'b0});
`else
    check("t6_price", {out_valid, out_price, out_err}, {1'b1, c_neg, 1'b0});
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
`default_nettype wire
